// File: rtl/mips_trace_checker.sv
// mips_trace_checker: compares the core's per-retirement (PC, ALU result)
// stream against a preloaded expected trace. It counts mismatches, catches
// stalls with a timeout, and reports pass or fail.
module mips_trace_checker #(
    parameter int DEPTH            = 16,
    parameter int IDX_W            = 4,
    parameter int TIMEOUT          = 64,
    parameter int HALT_ON_MISMATCH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W:0]   run_len,
    input  logic             exp_we,
    input  logic [IDX_W-1:0] exp_addr,
    input  logic [31:0]      exp_pc,
    input  logic [31:0]      exp_alu,
    input  logic             sample_valid,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      alu_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [7:0]       err_count,
    output logic [IDX_W-1:0] first_err_idx,
    output logic [IDX_W:0]   cur_idx
);

    localparam int             STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W:0]     cur_idx_reg, cur_idx_next;
    logic [IDX_W:0]     run_len_reg, run_len_next;
    logic [7:0]         err_reg, err_next;
    logic [IDX_W-1:0]   first_err_reg, first_err_next;
    logic               timeout_reg, timeout_next;
    logic [STALL_W-1:0] stall_reg, stall_next;

    // Expected trace: {pc, alu} per entry.
    logic [63:0]        mem [DEPTH];
    logic [63:0]        rd_data_reg;
    logic [IDX_W-1:0]   rd_addr;
    logic               mem_we;
    logic               mismatch;

    // The trace is writable only while no run is in progress, and only in range.
    assign mem_we = exp_we && (state_reg != ST_RUN) && ({1'b0, exp_addr} < DEPTH_W);

    // The entry needed next cycle is the one at the next index. Prefetching it
    // hides the registered-read latency. Past the end, address 0 is read harmlessly.
    always_comb begin
        rd_addr = '0;
        if (cur_idx_next < DEPTH_W) begin
            rd_addr = cur_idx_next[IDX_W-1:0];
        end
    end

    // Trace RAM with registered read. A write to the entry being prefetched
    // on the same edge is forwarded, so start plus write is coherent.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[exp_addr] <= {exp_pc, exp_alu};
        end
        if (mem_we && (exp_addr == rd_addr)) begin
            rd_data_reg <= {exp_pc, exp_alu};
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign mismatch = (pc_in != rd_data_reg[63:32]) || (alu_in != rd_data_reg[31:0]);

    // Next-state and datapath updates. Every run starts from a clean slate.
    always_comb begin
        state_next     = state_reg;
        cur_idx_next   = cur_idx_reg;
        run_len_next   = run_len_reg;
        err_next       = err_reg;
        first_err_next = first_err_reg;
        timeout_next   = timeout_reg;
        stall_next     = stall_reg;

        case (state_reg)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_next     = ST_RUN;
                    cur_idx_next   = '0;
                    err_next       = '0;
                    first_err_next = '0;
                    timeout_next   = 1'b0;
                    stall_next     = '0;
                    run_len_next   = ((run_len == '0) || (run_len > DEPTH_W)) ? DEPTH_W : run_len;
                end
            end
            ST_RUN: begin
                if (sample_valid) begin
                    cur_idx_next = cur_idx_reg + 1'b1;
                    stall_next   = '0;
                    if (mismatch) begin
                        if (err_reg != 8'hFF) begin
                            err_next = err_reg + 8'd1;
                        end
                        if (err_reg == 8'd0) begin
                            first_err_next = cur_idx_reg[IDX_W-1:0];
                        end
                    end
                    if (mismatch && (HALT_ON_MISMATCH != 0)) begin
                        state_next = ST_FAIL;
                    end else if (cur_idx_next == run_len_reg) begin
                        state_next = ST_DONE;
                    end
                end else begin
                    stall_next = stall_reg + 1'b1;
                    if (stall_reg == STALL_W'(TIMEOUT - 1)) begin
                        state_next   = ST_FAIL;
                        timeout_next = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and status registers. Reset wins over everything, but the trace RAM is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cur_idx_reg   <= '0;
            run_len_reg   <= '0;
            err_reg       <= '0;
            first_err_reg <= '0;
            timeout_reg   <= 1'b0;
            stall_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            cur_idx_reg   <= cur_idx_next;
            run_len_reg   <= run_len_next;
            err_reg       <= err_next;
            first_err_reg <= first_err_next;
            timeout_reg   <= timeout_next;
            stall_reg     <= stall_next;
        end
    end

    assign busy          = (state_reg == ST_RUN);
    assign done          = (state_reg == ST_DONE) || (state_reg == ST_FAIL);
    assign pass          = (state_reg == ST_DONE) && (err_reg == 8'd0);
    assign fail          = (state_reg == ST_FAIL) || ((state_reg == ST_DONE) && (err_reg != 8'd0));
    assign timeout       = timeout_reg;
    assign err_count     = err_reg;
    assign first_err_idx = first_err_reg;
    assign cur_idx       = cur_idx_reg;

endmodule

// File: tb/tb_mips_trace_checker.sv
// Testbench for mips_trace_checker. Two instances share all inputs: one halts
// on the first mismatch and one keeps counting. A run-level behavioural model
// predicts every output every cycle. Directed scenarios pin known outcomes,
// and randomized runs follow them.
module tb_mips_trace_checker;

    localparam int DEPTH   = 16;
    localparam int IDX_W   = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset, start, exp_we, sample_valid;
    logic [4:0]  run_len;
    logic [3:0]  exp_addr;
    logic [31:0] exp_pc, exp_alu, pc_in, alu_in;

    logic [1:0]  busy_o, done_o, pass_o, fail_o, to_o;
    logic [7:0]  err_o   [2];
    logic [3:0]  first_o [2];
    logic [4:0]  idx_o   [2];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    logic [31:0] tb_pc  [DEPTH];
    logic [31:0] tb_alu [DEPTH];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            mips_trace_checker #(
                .DEPTH(DEPTH), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT),
                .HALT_ON_MISMATCH((gi == 0) ? 1 : 0)
            ) dut (
                .clk(clk), .reset(reset), .start(start), .run_len(run_len),
                .exp_we(exp_we), .exp_addr(exp_addr), .exp_pc(exp_pc), .exp_alu(exp_alu),
                .sample_valid(sample_valid), .pc_in(pc_in), .alu_in(alu_in),
                .busy(busy_o[gi]), .done(done_o[gi]), .pass(pass_o[gi]), .fail(fail_o[gi]),
                .timeout(to_o[gi]), .err_count(err_o[gi]), .first_err_idx(first_o[gi]),
                .cur_idx(idx_o[gi])
            );
        end
    endgenerate

    // ---------------- behavioural model (index 0 halts, index 1 continues) -------
    bit          m_act [2], m_fin [2], m_bad [2], m_to [2];
    int          m_err [2], m_first [2], m_cnt [2], m_len [2], m_stall [2];
    logic [63:0] m_mem [2][DEPTH];

    always @(posedge clk) begin : model
        bit miss;
        for (int h = 0; h < 2; h++) begin
            if (reset) begin
                m_act[h] = 0; m_fin[h] = 0; m_bad[h] = 0; m_to[h] = 0;
                m_err[h] = 0; m_first[h] = 0; m_cnt[h] = 0; m_len[h] = 0; m_stall[h] = 0;
            end else if (!m_act[h]) begin
                if (exp_we && (int'(exp_addr) < DEPTH)) m_mem[h][exp_addr] = {exp_pc, exp_alu};
                if (start) begin
                    m_act[h] = 1; m_fin[h] = 0; m_bad[h] = 0; m_to[h] = 0;
                    m_err[h] = 0; m_first[h] = 0; m_cnt[h] = 0; m_stall[h] = 0;
                    m_len[h] = (run_len == 0 || int'(run_len) > DEPTH) ? DEPTH : int'(run_len);
                end
            end else if (sample_valid) begin
                miss = ({pc_in, alu_in} != m_mem[h][m_cnt[h]]);
                m_stall[h] = 0;
                if (miss) begin
                    if (m_err[h] == 0) m_first[h] = m_cnt[h];
                    if (m_err[h] < 255) m_err[h]++;
                end
                m_cnt[h]++;
                if (miss && h == 0) begin
                    m_act[h] = 0; m_fin[h] = 1; m_bad[h] = 1;
                end else if (m_cnt[h] == m_len[h]) begin
                    m_act[h] = 0; m_fin[h] = 1;
                end
            end else begin
                m_stall[h]++;
                if (m_stall[h] == TIMEOUT) begin
                    m_act[h] = 0; m_fin[h] = 1; m_bad[h] = 1; m_to[h] = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ------------------------
    always @(negedge clk) begin : compare
        logic [21:0] got, want;
        if (chk_en) begin
            for (int h = 0; h < 2; h++) begin
                got  = {busy_o[h], done_o[h], pass_o[h], fail_o[h], to_o[h],
                        err_o[h], first_o[h], idx_o[h]};
                want = {m_act[h], m_fin[h], (m_fin[h] && !m_bad[h] && m_err[h] == 0),
                        (m_fin[h] && (m_bad[h] || m_err[h] != 0)), m_to[h],
                        8'(m_err[h]), 4'(m_first[h]), 5'(m_cnt[h])};
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL cycle_dut%0d t=%0t: got busy/done/pass/fail/to=%b%b%b%b%b err=%0d first=%0d idx=%0d, want %b%b%b%b%b err=%0d first=%0d idx=%0d",
                             h, $time, got[21], got[20], got[19], got[18], got[17], got[16:9], got[8:5], got[4:0],
                             want[21], want[20], want[19], want[18], want[17], want[16:9], want[8:5], want[4:0]);
                end
            end
        end
    end

    // ---------------- driver helpers ---------------------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_in();
        reset = 0; start = 0; exp_we = 0; sample_valid = 0; run_len = '0;
        exp_addr = '0; exp_pc = '0; exp_alu = '0; pc_in = '0; alu_in = '0;
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
        $display("check %s: got 0x%0h want 0x%0h", name, got, want);
    endtask

    task automatic do_start(input logic [4:0] len);
        start = 1; run_len = len; tick(); start = 0;
    endtask

    task automatic sample(input logic [31:0] pc, input logic [31:0] alu);
        sample_valid = 1; pc_in = pc; alu_in = alu; tick(); sample_valid = 0;
    endtask

    task automatic good(input int i);
        sample(tb_pc[i], tb_alu[i]);
    endtask

    // ---------------- stimulus ------------------------------------------------
    initial begin : driver
        int n;
        clear_in();
        reset = 1;
        tick();
        chk_en = 1;
        tick();
        reset = 0;
        lit("reset_busy", busy_o[0], 0);
        lit("reset_done", done_o[0], 0);
        lit("reset_err",  err_o[1], 0);

        // Load the full trace: the three listed entries, then random data.
        for (int i = 0; i < DEPTH; i++) begin
            tb_pc[i]  = (i < 3) ? 32'(4 * i) : $urandom;
            tb_alu[i] = (i < 3) ? 32'(5 + 5 * i) : $urandom;
            exp_we = 1; exp_addr = 4'(i); exp_pc = tb_pc[i]; exp_alu = tb_alu[i];
            tick();
        end
        exp_we = 0;

        // 1: three matching samples give a pass.
        do_start(5'd3); good(0); good(1); good(2);
        lit("s1_done", done_o[0], 1); lit("s1_pass", pass_o[0], 1);
        lit("s1_err", err_o[0], 0);   lit("s1_idx", idx_o[0], 3);

        // 2: a wrong ALU at index 2 halts.
        do_start(5'd3); good(0); good(1); sample(32'h8, 32'hE);
        lit("s2_fail", fail_o[0], 1); lit("s2_err", err_o[0], 1);
        lit("s2_first", first_o[0], 2); lit("s2_timeout", to_o[0], 0);

        // 3: the non-halting instance counts two errors over four entries.
        do_start(5'd4); good(0); sample(tb_pc[1] ^ 32'h4, tb_alu[1]); good(2);
        sample(tb_pc[3], tb_alu[3] + 1);
        lit("s3_done", done_o[1], 1); lit("s3_fail", fail_o[1], 1);
        lit("s3_err", err_o[1], 2);   lit("s3_first", first_o[1], 1);
        lit("s3_idx", idx_o[1], 4);   lit("s3_halt_idx", idx_o[0], 2);

        // 4: the stall timeout fires exactly TIMEOUT cycles after the last sample.
        do_start(5'd4); good(0);
        n = 0;
        while (!fail_o[0] && n < 200) begin tick(); n++; end
        lit("s4_cycles", n, 64); lit("s4_timeout", to_o[0], 1); lit("s4_idx", idx_o[0], 1);

        // 5: a write during a run is dropped, so a restart still passes.
        do_start(5'd3);
        exp_we = 1; exp_addr = 0; exp_pc = 32'hDEAD; exp_alu = 32'hBEEF; tick(); exp_we = 0;
        good(0); good(1); good(2);
        do_start(5'd3); good(0); good(1); good(2);
        lit("s5_pass", pass_o[0], 1);

        // 6: a reset mid-run clears status, and memory survives it.
        do_start(5'd4); good(0); good(1);
        reset = 1; tick(); reset = 0;
        lit("s6_busy", busy_o[0], 0); lit("s6_done", done_o[0], 0); lit("s6_err", err_o[0], 0);
        do_start(5'd3); good(0); good(1); good(2);
        lit("s6_pass", pass_o[0], 1);

        // 7: a run_len of 0 is clamped to the full depth.
        do_start(5'd0);
        for (int i = 0; i < DEPTH; i++) good(i);
        lit("s7_pass", pass_o[0], 1); lit("s7_idx", idx_o[0], 16);

        // Randomized runs, checked every cycle against the model.
        for (int r = 0; r < 60; r++) begin
            int vp, cyc, k;
            case ($urandom_range(0, 2))
                0:       vp = 90;
                1:       vp = 50;
                default: vp = 2;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                exp_we = 1; exp_addr = 4'($urandom_range(0, 15));
                exp_pc = $urandom; exp_alu = $urandom; tick(); exp_we = 0;
            end
            do_start(5'($urandom_range(0, 31)));
            cyc = 0;
            while ((m_act[0] || m_act[1]) && cyc < 3000) begin
                k = m_cnt[1] % DEPTH;
                sample_valid = ($urandom_range(0, 99) < vp);
                pc_in  = m_mem[1][k][63:32];
                alu_in = m_mem[1][k][31:0];
                if ($urandom_range(0, 9) == 0) pc_in  = pc_in ^ (32'd1 << $urandom_range(0, 31));
                if ($urandom_range(0, 9) == 0) alu_in = alu_in ^ (32'd1 << $urandom_range(0, 31));
                exp_we   = ($urandom_range(0, 7) == 0);
                exp_addr = 4'($urandom_range(0, 15));
                exp_pc   = $urandom; exp_alu = $urandom;
                start    = ($urandom_range(0, 39) == 0);
                run_len  = 5'($urandom_range(0, 31));
                reset    = ($urandom_range(0, 499) == 0);
                tick();
                cyc++;
            end
            clear_in();
            vectors++;
            if (cyc >= 3000) begin
                miscompares++;
                $display("FAIL random_run_%0d: still busy after %0d cycles, want idle", r, cyc);
            end
            $display("random run %0d: %0d cycles, err h=%0d c=%0d", r, cyc, m_err[0], m_err[1]);
            tick();
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_trace_checker.md
Name: mips_trace_checker

Overview:
- Consumer end of the core's observation interface (`pc_out`, `alu_result`).
- Holds an expected per-cycle trace of PC and ALU result pairs, loaded through a write port before a run.
- During a run it compares each sampled core output against the next expected entry, counts mismatches and detects stalls.
- Reports pass/fail, so self-checking benches and on-board bring-up can stop hand-driven clock sequences and visual waveform checks.

Parameters:
- DEPTH, 16, number of expected trace entries (2..256).
- IDX_W, 4, width of the trace index; must satisfy 2^IDX_W >= DEPTH.
- TIMEOUT, 64, maximum consecutive RUN cycles without `sample_valid` before a failure is declared.
- HALT_ON_MISMATCH, 1, 1 = stop at the first mismatch; 0 = count mismatches and continue.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run.
- run_len  in  IDX_W+1  number of entries to check (1..DEPTH); sampled on `start`.
- exp_we  in  1  expected-trace write enable.
- exp_addr  in  IDX_W  expected-trace write address.
- exp_pc  in  32  expected PC for the entry.
- exp_alu  in  32  expected ALU result for the entry.
- sample_valid  in  1  core retired one instruction this cycle; `pc_in`/`alu_in` are valid.
- pc_in  in  32  core `pc_out`.
- alu_in  in  32  core `alu_result`.
- busy  out  1  high in RUN.
- done  out  1  high in DONE or FAIL.
- pass  out  1  high in DONE with `err_count` == 0.
- fail  out  1  high in FAIL, or in DONE with `err_count` != 0.
- timeout  out  1  the failure was caused by the stall timeout.
- err_count  out  8  mismatch count, saturating at 255.
- first_err_idx  out  IDX_W  index of the first mismatching entry.
- cur_idx  out  IDX_W+1  number of entries compared so far.

Behaviour:
- Reset (synchronous, active-high; takes priority over everything, including mid-run):
  - state = IDLE.
  - All outputs cleared to 0.
  - Index, stall counter and `run_len` register cleared to 0.
  - Trace memory contents are not cleared.
- State IDLE:
  - `exp_we` writes `{exp_pc, exp_alu}` to `mem[exp_addr]` on the clock edge.
  - Writes with `exp_addr` >= DEPTH are dropped.
  - `start` -> RUN. On that transition: `cur_idx` = 0, `err_count` = 0, `first_err_idx` = 0, `timeout` = 0, stall counter = 0, `run_len` latched.
  - `run_len` of 0 or > DEPTH is clamped to DEPTH.
- State RUN:
  - `exp_we` is ignored (memory is read-only during a run).
  - `start` is ignored.
  - Each cycle with `sample_valid`:
    - compare `pc_in` and `alu_in` against `mem[cur_idx]`;
    - a mismatch on either field is one error;
    - `cur_idx` increments;
    - stall counter is cleared.
  - On a mismatch:
    - `err_count` increments, saturating at 255;
    - if it is the first error of the run, `first_err_idx` = `cur_idx` (pre-increment);
    - if HALT_ON_MISMATCH = 1, go to FAIL on the same edge.
  - Each cycle without `sample_valid`, the stall counter increments. When it reaches TIMEOUT, go to FAIL with `timeout` = 1.
  - When the incremented `cur_idx` equals `run_len`, go to DONE. A halting mismatch on the last entry goes to FAIL instead.
- States DONE and FAIL:
  - `done` = 1.
  - `pass`/`fail` are held until `start` or reset.
  - `sample_valid` is ignored.
  - `exp_we` is accepted, so the trace can be reloaded.
  - `start` re-enters RUN with the same initialisation as in IDLE.
- Latency:
  - All outputs are registered.
  - Status reflects a sample one cycle after the edge on which it was taken.
  - `done`, `pass` and `fail` assert one cycle after the deciding sample or the timeout.
- Comparison is exact 32-bit equality on both fields; there are no don't-care masks.

Test Plan:
- Load 3 entries `(0x0,0x5)`, `(0x4,0xA)`, `(0x8,0xF)`, `run_len` = 3, start, drive the matching samples on consecutive cycles -> `done` = 1, `pass` = 1, `err_count` = 0, `cur_idx` = 3 one cycle after the third sample.
- Same load with HALT_ON_MISMATCH = 1, drive `alu_in` = 0xE at index 2 -> `fail` = 1, `err_count` = 1, `first_err_idx` = 2, `timeout` = 0.
- HALT_ON_MISMATCH = 0, 4 entries, wrong PC at index 1 and wrong ALU at index 3 -> `done` = 1, `fail` = 1, `err_count` = 2, `first_err_idx` = 1, `cur_idx` = 4.
- Start with TIMEOUT = 64, one valid sample, then hold `sample_valid` = 0 -> `fail` = 1, `timeout` = 1 exactly 64 cycles after the last sample; `cur_idx` = 1.
- During RUN, pulse `exp_we` to entry 0 with different data, then restart from DONE -> the original entry 0 still matches, so `pass` = 1.
- Assert `reset` for one cycle at `cur_idx` = 2 mid-run -> next cycle `busy` = 0, `done` = 0, `err_count` = 0; a new start with unchanged memory passes.
